core_ctrl_fsm: RTL and testbench

//  Multi-cycle sequencer for the single-issue RV32I core datapath (register file, load/store unit, data memory, ALU).

---
 rtl/core_ctrl_pkg.sv | 51 +++++
 rtl/core_ctrl_imm_gen.sv | 14 +
 rtl/core_ctrl_fsm.sv | 190 +++++++++++++++++++
 tb/tb_core_ctrl_fsm.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle control sequencer.
// Misalignment and byte-lane helpers are keyed on the access-width bits func3[1:0].
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    TRAP_NONE      = 2'd0,
    TRAP_ILLEGAL   = 2'd1,
    TRAP_MISALIGN  = 2'd2,
    TRAP_FETCH_TMO = 2'd3
  } trap_e;

  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if (width == F3_W[1:0] && lo != 2'b00) bad = 1'b1;
    if (width == F3_H[1:0] && lo[0]) bad = 1'b1;
    return bad;
  endfunction

  // Unknown widths fall through to a full-word store.
  function automatic logic [3:0] store_lanes(input logic [1:0] width, input logic [1:0] lo);
    logic [3:0] lanes;
    if (width == F3_B[1:0]) lanes = 4'b0001 << lo;
    else if (width == F3_H[1:0]) lanes = 4'b0011 << lo;
    else lanes = 4'b1111;
    return lanes;
  endfunction

endpackage

// File: rtl/core_ctrl_imm_gen.sv
// Immediate generator: sign-extended S-format for stores, I-format otherwise.
module imm_gen
  import core_ctrl_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = {{20{ir_i[31]}}, ir_i[31:20]};
    if (ir_i[6:0] == OP_STORE) imm_o = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
  end

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute sequencer driving the RV32I datapath control strobes.
// state      | meaning
// IDLE       | stopped, waiting for run
// FETCH      | imem_req high, waiting on imem_ready (timeout -> HALT)
// DECODE     | opcode check; SYSTEM/illegal -> HALT
// EXECUTE    | ALU/address settle, alignment check for memory ops
// MEMORY     | store strobe, or first load-data cycle
// WRITEBACK  | register-file write strobe
// HALT       | terminal until reset
module core_ctrl_fsm
  import core_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [7:0]  FETCH_TMO = 8'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  mem_addr_lo,
  output logic        reg_write,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [31:0] imm,
  output logic [3:0]  mem_write_enable,
  output logic        store_enable,
  output logic        load_enable,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        halted,
  output logic [1:0]  trap_cause
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  tmo_q, tmo_d;
  trap_e       trap_q, trap_d;
  logic        imem_req_q, imem_req_d;
  logic        reg_write_q, reg_write_d;
  logic        store_q, store_d;
  logic        load_q, load_d;
  logic [3:0]  wme_q, wme_d;
  logic        halted_q, halted_d;
  logic        retire;
  logic        is_load, is_store;

  assign is_load  = (ir_q[6:0] == OP_LOAD);
  assign is_store = (ir_q[6:0] == OP_STORE);

  imm_gen u_imm_gen (
    .ir_i  (ir_q),
    .imm_o (imm)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    ir_d      = ir_q;
    tmo_d     = tmo_q;
    trap_d    = trap_q;
    wme_d     = wme_q;
    retire    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end else if (tmo_q <= 8'd1) begin
          state_d = ST_HALT;
          trap_d  = TRAP_FETCH_TMO;
        end else begin
          tmo_d = tmo_q - 8'd1;
        end
      end
      ST_DECODE: begin
        case (ir_q[6:0])
          OP_ALU_R, OP_ALU_I, OP_LOAD, OP_STORE: state_d = ST_EXECUTE;
          OP_SYSTEM: begin
            // SYSTEM halts cleanly and counts as retired, but the PC stays on it.
            state_d   = ST_HALT;
            trap_d    = TRAP_NONE;
            retired_d = retired_q + 32'd1;
          end
          default: begin
            state_d = ST_HALT;
            trap_d  = TRAP_ILLEGAL;
          end
        endcase
      end
      ST_EXECUTE: begin
        if (is_load || is_store) begin
          if (is_misaligned(ir_q[13:12], mem_addr_lo)) begin
            state_d = ST_HALT;
            trap_d  = TRAP_MISALIGN;
          end else begin
            state_d = ST_MEMORY;
            if (is_store) wme_d = store_lanes(ir_q[13:12], mem_addr_lo);
          end
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEMORY: begin
        if (is_store) retire = 1'b1;
        else state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: retire = 1'b1;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase

    if (retire) begin
      pc_d      = pc_q + 32'd4;
      retired_d = retired_q + 32'd1;
      state_d   = run ? ST_FETCH : ST_IDLE;
    end

    if (state_d == ST_FETCH && state_q != ST_FETCH) tmo_d = FETCH_TMO;
    if (state_d != ST_MEMORY) wme_d = 4'b0000;

    // Strobes are registered off the next state so they line up with their phase.
    imem_req_d  = (state_d == ST_FETCH);
    store_d     = (state_d == ST_MEMORY) && is_store;
    load_d      = (state_d == ST_MEMORY || state_d == ST_WRITEBACK) && is_load;
    reg_write_d = (state_d == ST_WRITEBACK) && (ir_q[11:7] != 5'd0);
    halted_d    = (state_d == ST_HALT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      retired_q   <= 32'd0;
      ir_q        <= 32'd0;
      tmo_q       <= 8'd0;
      trap_q      <= TRAP_NONE;
      imem_req_q  <= 1'b0;
      reg_write_q <= 1'b0;
      store_q     <= 1'b0;
      load_q      <= 1'b0;
      wme_q       <= 4'b0000;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      retired_q   <= retired_d;
      ir_q        <= ir_d;
      tmo_q       <= tmo_d;
      trap_q      <= trap_d;
      imem_req_q  <= imem_req_d;
      reg_write_q <= reg_write_d;
      store_q     <= store_d;
      load_q      <= load_d;
      wme_q       <= wme_d;
      halted_q    <= halted_d;
    end
  end

  assign imem_req         = imem_req_q;
  assign imem_addr        = pc_q;
  assign pc               = pc_q;
  assign retired          = retired_q;
  assign reg_write        = reg_write_q;
  assign store_enable     = store_q;
  assign load_enable      = load_q;
  assign mem_write_enable = wme_q;
  assign halted           = halted_q;
  assign trap_cause       = trap_q;
  assign rd               = ir_q[11:7];
  assign rs1              = ir_q[19:15];
  assign rs2              = ir_q[24:20];
  assign opcode           = ir_q[6:0];
  assign func3            = ir_q[14:12];
  assign func7            = ir_q[31:25];

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Self-checking bench for core_ctrl_fsm: instruction vector table with a scoreboard queue,
// plus directed sequences for timeout, run drop, async reset and retired wrap.
module tb_core_ctrl_fsm;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [1:0]  mem_addr_lo = 2'd0;
  logic        imem_req, reg_write, store_enable, load_enable, halted;
  logic [31:0] imem_addr, imm, pc, retired;
  logic [4:0]  rd, rs1, rs2;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic [3:0]  mem_write_enable;
  logic [1:0]  trap_cause;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  lo;
    int          waits;
    int          cyc;
    int          rw_at;
    int          st_cnt;
    logic [3:0]  wme;
    int          ld_cnt;
    logic        halt;
    logic [1:0]  trap;
    logic [31:0] pc_inc;
    logic [31:0] ret_inc;
    logic [31:0] imm;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[15];
  vec_t exp_q[$];

  core_ctrl_fsm dut (
    .clock            (clock),
    .reset            (reset),
    .run              (run),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .mem_addr_lo      (mem_addr_lo),
    .reg_write        (reg_write),
    .rd               (rd),
    .rs1              (rs1),
    .rs2              (rs2),
    .opcode           (opcode),
    .func3            (func3),
    .func7            (func7),
    .imm              (imm),
    .mem_write_enable (mem_write_enable),
    .store_enable     (store_enable),
    .load_enable      (load_enable),
    .pc               (pc),
    .retired          (retired),
    .halted           (halted),
    .trap_cause       (trap_cause)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    run = 1'b0;
    imem_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Runs one instruction from IDLE; run is dropped once the fetch is accepted.
  task automatic exec(input vec_t v, input string tag);
    vec_t e;
    logic [31:0] pc0, ret0;
    logic [3:0] wme;
    int n, fcnt, rw_cnt, rw_at, st_cnt, ld_cnt, bad;
    bit done;
    exp_q.push_back(v);
    pc0 = pc; ret0 = retired; wme = 4'h0;
    n = 0; fcnt = 0; rw_cnt = 0; rw_at = 0; st_cnt = 0; ld_cnt = 0; bad = 0; done = 0;
    mem_addr_lo = v.lo;
    run = 1'b1;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
      if (halted || retired != ret0) begin
        done = 1;
      end else begin
        if (reg_write) begin rw_cnt++; rw_at = n; end
        if (store_enable) begin st_cnt++; wme = mem_write_enable; end
        if (load_enable) ld_cnt++;
        if (imem_req && (reg_write || store_enable || mem_write_enable != 4'h0)) bad++;
        if (!store_enable && mem_write_enable != 4'h0) bad++;
        if (imem_req) begin
          fcnt++;
          if (fcnt > v.waits) begin
            imem_ready = 1'b1; imem_rdata = v.instr; run = 1'b0;
          end else imem_ready = 1'b0;
        end else imem_ready = 1'b0;
      end
    end
    imem_ready = 1'b0;
    run = 1'b0;
    e = exp_q.pop_front();
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".cycles"}, n - 1, e.cyc);
    check({tag, ".rw_cnt"}, rw_cnt, (e.rw_at != 0) ? 1 : 0);
    check({tag, ".rw_at"}, rw_at, e.rw_at);
    check({tag, ".st_cnt"}, st_cnt, e.st_cnt);
    check({tag, ".wme"}, 32'(wme), 32'(e.wme));
    check({tag, ".ld_cnt"}, ld_cnt, e.ld_cnt);
    check({tag, ".halted"}, 32'(halted), 32'(e.halt));
    check({tag, ".trap"}, 32'(trap_cause), 32'(e.trap));
    check({tag, ".pc_inc"}, pc - pc0, e.pc_inc);
    check({tag, ".ret_inc"}, retired - ret0, e.ret_inc);
    check({tag, ".imm"}, imm, e.imm);
    check({tag, ".rd"}, 32'(rd), 32'(e.rd));
    check({tag, ".strobe_phase"}, bad, 0);
    if (e.halt) do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vec_t w;
    int cnt;
    //             instr          lo    w  cyc rw st wme   ld halt trap  pc_inc ret_inc imm            rd
    vecs[0]  = '{32'h00500093, 2'd0, 0, 4, 4, 0, 4'h0, 0, 1'b0, 2'd0, 32'd4, 32'd1, 32'd5,         5'd1};
    vecs[1]  = '{32'h0020A423, 2'd0, 0, 4, 0, 1, 4'hF, 0, 1'b0, 2'd0, 32'd4, 32'd1, 32'd8,         5'd8};
    vecs[2]  = '{32'h002081A3, 2'd3, 0, 4, 0, 1, 4'h8, 0, 1'b0, 2'd0, 32'd4, 32'd1, 32'd3,         5'd3};
    vecs[3]  = '{32'h00209123, 2'd2, 0, 4, 0, 1, 4'hC, 0, 1'b0, 2'd0, 32'd4, 32'd1, 32'd2,         5'd2};
    vecs[4]  = '{32'h0000A183, 2'd0, 0, 5, 5, 0, 4'h0, 2, 1'b0, 2'd0, 32'd4, 32'd1, 32'd0,         5'd3};
    vecs[5]  = '{32'h00009183, 2'd1, 0, 3, 0, 0, 4'h0, 0, 1'b1, 2'd2, 32'd0, 32'd0, 32'd0,         5'd3};
    vecs[6]  = '{32'hFFF00293, 2'd0, 3, 7, 7, 0, 4'h0, 0, 1'b0, 2'd0, 32'd4, 32'd1, 32'hFFFFFFFF,  5'd5};
    vecs[7]  = '{32'h00100013, 2'd0, 0, 4, 0, 0, 4'h0, 0, 1'b0, 2'd0, 32'd4, 32'd1, 32'd1,         5'd0};
    vecs[8]  = '{32'h00208233, 2'd0, 0, 4, 4, 0, 4'h0, 0, 1'b0, 2'd0, 32'd4, 32'd1, 32'd2,         5'd4};
    vecs[9]  = '{32'h00000073, 2'd0, 0, 2, 0, 0, 4'h0, 0, 1'b1, 2'd0, 32'd0, 32'd1, 32'd0,         5'd0};
    vecs[10] = '{32'h0000007F, 2'd0, 0, 2, 0, 0, 4'h0, 0, 1'b1, 2'd1, 32'd0, 32'd0, 32'd0,         5'd0};
    vecs[11] = '{32'h0020A423, 2'd1, 0, 3, 0, 0, 4'h0, 0, 1'b1, 2'd2, 32'd0, 32'd0, 32'd8,         5'd8};
    vecs[12] = '{32'hFE20AE23, 2'd0, 0, 4, 0, 1, 4'hF, 0, 1'b0, 2'd0, 32'd4, 32'd1, 32'hFFFFFFFC,  5'd28};
    vecs[13] = '{32'h00008183, 2'd3, 0, 5, 5, 0, 4'h0, 2, 1'b0, 2'd0, 32'd4, 32'd1, 32'd0,         5'd3};
    vecs[14] = '{32'h00209123, 2'd3, 0, 3, 0, 0, 4'h0, 0, 1'b1, 2'd2, 32'd0, 32'd0, 32'd2,         5'd2};

    #2 reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst.imem_req", 32'(imem_req), 32'd0);
    check("rst.pc", pc, 32'd0);
    check("rst.imem_addr", imem_addr, 32'd0);
    check("rst.retired", retired, 32'd0);
    check("rst.halted", 32'(halted), 32'd0);
    check("rst.trap", 32'(trap_cause), 32'd0);
    check("rst.strobes", {reg_write, store_enable, load_enable, mem_write_enable}, 32'd0);
    check("rst.fields", {rd, rs1, rs2, opcode, func3}, 32'd0);
    check("rst.imm", imm, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("idle.no_req", 32'(imem_req), 32'd0);

    for (int i = 0; i < 15; i++) exec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back with run held, then run dropped during EXECUTE of ADD.
    do_reset();
    run = 1'b1;
    mem_addr_lo = 2'd0;
    @(negedge clock);
    imem_ready = 1'b1; imem_rdata = 32'h00500093;
    @(negedge clock); imem_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("b2b.rw_c4", 32'(reg_write), 32'd1);
    @(negedge clock);
    check("b2b.refetch", 32'(imem_req), 32'd1);
    check("b2b.pc", pc, 32'd4);
    check("b2b.retired", retired, 32'd1);
    imem_ready = 1'b1; imem_rdata = 32'h00208233;
    @(negedge clock); imem_ready = 1'b0;
    @(negedge clock); run = 1'b0;
    @(negedge clock);
    check("drop.wb", 32'(reg_write), 32'd1);
    check("drop.rd", 32'(rd), 32'd4);
    @(negedge clock);
    check("drop.retired", retired, 32'd2);
    check("drop.pc", pc, 32'd8);
    @(negedge clock);
    check("drop.idle", 32'(imem_req), 32'd0);

    // Async reset while a store strobe is high.
    run = 1'b1;
    @(negedge clock);
    imem_ready = 1'b1; imem_rdata = 32'h0020A423; run = 1'b0;
    @(negedge clock); imem_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("arst.store_before", 32'(store_enable), 32'd1);
    check("arst.pc_before", pc, 32'd8);
    #1 reset = 1'b0;
    #1;
    check("arst.store_after", 32'(store_enable), 32'd0);
    check("arst.wme_after", 32'(mem_write_enable), 32'd0);
    check("arst.pc_after", pc, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Fetch timeout with imem_ready held low.
    run = 1'b1;
    imem_ready = 1'b0;
    cnt = 0;
    for (int k = 0; k < 400 && !halted; k++) begin
      @(negedge clock);
      if (imem_req) cnt++;
    end
    check("tmo.halted", 32'(halted), 32'd1);
    check("tmo.req_cycles", cnt, 255);
    check("tmo.trap", 32'(trap_cause), 32'd3);
    check("tmo.pc", pc, 32'd0);
    check("tmo.retired", retired, 32'd0);
    check("tmo.no_req", 32'(imem_req), 32'd0);
    do_reset();

    // Retired counter wraps from all-ones to zero.
    force dut.retired_q = 32'hFFFF_FFFF;
    @(negedge clock);
    release dut.retired_q;
    @(negedge clock);
    w = vecs[0];
    exec(w, "wrap");
    check("wrap.retired", retired, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
